// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller: FSM state encoding and
// the largest supported chain length.
package scan_pkg;

    localparam int MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_UPDATE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_shadow_reg.sv
// Shadow register of the scan chain: parallel capture from the chip, serial
// LSB-first shift, and running parity of the bits shifted out and shifted in.
// The parity accumulators exist only when SCAN_CHAIN_PARITY_EN is defined;
// otherwise out_par/in_par are tied low.
module scan_shadow_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             par_clr,
    input  logic             scan_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] shadow,
    output logic             out_par,
    output logic             in_par
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] shifted;

    // A one-cell chain has nothing to shift along; the new bit simply replaces it.
    generate
        if (WIDTH == 1) begin : g_one_cell
            assign shifted = scan_in;
        end else begin : g_multi_cell
            assign shifted = {scan_in, shadow_q[WIDTH-1:1]};
        end
    endgenerate

    // Next shadow value: capture has priority, the controller never asserts both.
    always_comb begin
        shadow_d = shadow_q;
        if (load_en) begin
            shadow_d = load_data;
        end else if (shift_en) begin
            shadow_d = shifted;
        end
    end

    // Shadow register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

`ifdef SCAN_CHAIN_PARITY_EN
    logic out_par_q;
    logic out_par_d;
    logic in_par_q;
    logic in_par_d;

    // Accumulate parity of every bit leaving and entering the chain.
    always_comb begin
        out_par_d = out_par_q;
        in_par_d  = in_par_q;
        if (par_clr) begin
            out_par_d = 1'b0;
            in_par_d  = 1'b0;
        end else if (shift_en) begin
            out_par_d = out_par_q ^ shadow_q[0];
            in_par_d  = in_par_q ^ scan_in;
        end
    end

    // Parity accumulator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par_q <= 1'b0;
            in_par_q  <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
            in_par_q  <= in_par_d;
        end
    end

    assign out_par = out_par_q;
    assign in_par  = in_par_q;
`else
    logic unused_par_clr;
    assign unused_par_clr = par_clr;
    assign out_par        = 1'b0;
    assign in_par         = 1'b0;
`endif

endmodule

// File: rtl/scan_chain.sv
// Scan chain controller: IDLE -> (CAPTURE) -> SHIFT x WIDTH -> UPDATE -> IDLE.
// Optional macro SCAN_CHAIN_PARITY_EN adds one parity cycle at the end of
// SHIFT and suppresses the UPDATE load on a parity mismatch.
//
// Handshake: start is a request that is accepted only on an edge where the
// block is in IDLE (busy=0); capture_en/update_en are sampled on that same
// edge only. Requests while busy=1 are dropped, not queued. done pulses for
// one cycle after the UPDATE exit edge, and a new start may be accepted in
// that same cycle.
module scan_chain
    import scan_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             capture_en,
    input  logic             update_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [WIDTH-1:0] chip_data_out,
    output logic [WIDTH-1:0] chip_data_in,
    output logic             busy,
    output logic             done,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("scan_chain: WIDTH out of range");
        end
    endgenerate

    // Counter value of the final SHIFT cycle; the counter stops there, so it
    // never wraps even when CW is a single bit.
`ifdef SCAN_CHAIN_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    scan_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cap_q, cap_d;
    logic             upd_q, upd_d;
    logic [WIDTH-1:0] chip_q, chip_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             par_err_q, par_err_d;

    logic             start_ok;
    logic             parity_cycle;
    logic             shift_en;
    logic             load_en;
    logic [WIDTH-1:0] shadow;
    logic             out_par;
    logic             in_par;

    assign start_ok = (state_q == ST_IDLE) && start;

`ifdef SCAN_CHAIN_PARITY_EN
    assign parity_cycle = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
`else
    assign parity_cycle = 1'b0;
`endif

    assign shift_en = (state_q == ST_SHIFT) && !parity_cycle;
    assign load_en  = (state_q == ST_CAPTURE) && cap_q;

    scan_shadow_reg #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .shift_en  (shift_en),
        .par_clr   (start_ok),
        .scan_in   (scan_in),
        .load_data (chip_data_out),
        .shadow    (shadow),
        .out_par   (out_par),
        .in_par    (in_par)
    );

    // Next-state and next-output logic of the controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        upd_d     = upd_q;
        chip_d    = chip_q;
        par_err_d = par_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_d     = capture_en;
                    upd_d     = update_en;
                    par_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = capture_en ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (parity_cycle && (scan_in != in_par)) begin
                    par_err_d = 1'b1;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_UPDATE: begin
                if (upd_q && !par_err_q) begin
                    chip_d = shadow;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_UPDATE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cap_q     <= 1'b0;
            upd_q     <= 1'b0;
            chip_q    <= RST_VAL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            upd_q     <= upd_d;
            chip_q    <= chip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
        end
    end

    assign scan_out     = parity_cycle ? out_par : shadow[0];
    assign chip_data_in = chip_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef SCAN_CHAIN_PARITY_EN
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain.sv
// Bench for scan_chain: an 8-cell instance driven by directed operations and
// checked by a done-triggered scoreboard, plus a 1-cell instance.
`timescale 1ns/1ps
module tb_scan_chain;
    import scan_pkg::*;

    localparam int W = 8;
`ifdef SCAN_CHAIN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start, capture_en, update_en, scan_in;
    logic         scan_out, busy, done, par_err;
    logic [W-1:0] chip_data_out, chip_data_in;

    logic         start1, capture_en1, update_en1, scan_in1;
    logic         scan_out1, busy1, done1, par_err1;
    logic [0:0]   chip_data_out1, chip_data_in1;

    scan_chain #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .capture_en    (capture_en),
        .update_en     (update_en),
        .scan_in       (scan_in),
        .scan_out      (scan_out),
        .chip_data_out (chip_data_out),
        .chip_data_in  (chip_data_in),
        .busy          (busy),
        .done          (done),
        .par_err       (par_err)
    );

    scan_chain #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .start         (start1),
        .capture_en    (capture_en1),
        .update_en     (update_en1),
        .scan_in       (scan_in1),
        .scan_out      (scan_out1),
        .chip_data_out (chip_data_out1),
        .chip_data_in  (chip_data_in1),
        .busy          (busy1),
        .done          (done1),
        .par_err       (par_err1)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] model_chip;
    int           st_q[$];
    int           lat_q[$];
    logic [W-1:0] exp_q[$];
    logic         perr_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive point: just after the falling edge, far from the active edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full operation on the 8-cell instance. exp_so is the content the
    // shadow holds when SHIFT begins (bits leave LSB first).
    task automatic run_op(input logic cap, input logic upd, input logic [W-1:0] cdo,
                          input logic [W-1:0] data, input logic [W-1:0] exp_so,
                          input logic pbit, input int poke_at);
        logic         par_ok;
        logic [W-1:0] new_chip;
        par_ok   = (PAR == 0) || ((^data) == pbit);
        new_chip = (upd && par_ok) ? data : model_chip;
        start         = 1'b1;
        capture_en    = cap;
        update_en     = upd;
        chip_data_out = cdo;
        st_q.push_back(cyc + 1);
        lat_q.push_back(W + 2 + PAR + (cap ? 1 : 0));
        exp_q.push_back(new_chip);
        perr_q.push_back(!par_ok);
        step();
        start      = 1'b0;
        capture_en = ~cap;
        update_en  = ~upd;
        check("start_clears_par_err", par_err, 0);
        if (cap) step();
        chip_data_out = ~cdo;
        for (int i = 0; i < W; i++) begin
            check("shift_scan_out", scan_out, exp_so[i]);
            check("shift_busy", busy, 1);
            check("shift_chip_hold", chip_data_in, model_chip);
            start   = (i == poke_at);
            scan_in = data[i];
            step();
        end
        start = 1'b0;
`ifdef SCAN_CHAIN_PARITY_EN
        check("parity_scan_out", scan_out, ^exp_so);
        scan_in = pbit;
        step();
`endif
        check("update_chip_hold", chip_data_in, model_chip);
        step();
        model_chip = new_chip;
    endtask

    // Scoreboard monitor: every done pulse retires the oldest expected entry.
    always @(negedge clk) begin
        int s;
        if (!rst && done) begin
            if (st_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op at cycle %0d", cyc);
            end else begin
                s = st_q.pop_front();
                check("done_latency", cyc - s + 1, lat_q.pop_front());
                check("done_chip_data_in", chip_data_in, exp_q.pop_front());
                check("done_par_err", par_err, perr_q.pop_front());
                check("done_busy", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int k;
        rst = 1'b1;
        start = 1'b0; capture_en = 1'b0; update_en = 1'b0; scan_in = 1'b0;
        chip_data_out = '0;
        start1 = 1'b0; capture_en1 = 1'b0; update_en1 = 1'b0; scan_in1 = 1'b0;
        chip_data_out1 = 1'b0;
        model_chip = '0;
        step();
        step();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_scan_out", scan_out, 0);
        check("reset_chip_data_in", chip_data_in, 0);
        check("reset_par_err", par_err, 0);
        rst = 1'b0;

        // Capture readback, start taken on the first edge after reset release.
        run_op(1'b1, 1'b0, 8'hA5, 8'h96, 8'hA5, 1'b0, -1);
        // Update without capture.
        run_op(1'b0, 1'b1, 8'h00, 8'h3C, 8'h96, 1'b0, -1);
        // Start pulsed on the 4th SHIFT cycle must be dropped.
        run_op(1'b1, 1'b1, 8'h5A, 8'h81, 8'h5A, 1'b0, 3);

        // Reset asserted in the 5th SHIFT cycle.
        start = 1'b1; capture_en = 1'b0; update_en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_in = 1'b1;
            step();
        end
        rst = 1'b1;
        #1;
        check("midshift_rst_busy", busy, 0);
        check("midshift_rst_done", done, 0);
        check("midshift_rst_scan_out", scan_out, 0);
        check("midshift_rst_chip", chip_data_in, 0);
        check("midshift_rst_state", dut.state_q, ST_IDLE);
        step();
        rst = 1'b0;
        model_chip = '0;

        run_op(1'b0, 1'b1, 8'h00, 8'hC3, 8'h00, 1'b0, -1);
        run_op(1'b1, 1'b0, 8'hFF, 8'h07, 8'hFF, 1'b1, -1);
        // Parity-relevant pair: good parity bit, then a wrong one.
        run_op(1'b0, 1'b1, 8'h00, 8'h07, 8'h07, 1'b1, -1);
        run_op(1'b0, 1'b1, 8'h00, 8'hE0, 8'h07, 1'b0, -1);
        check("par_err_holds_until_start", par_err, PAR);
        run_op(1'b0, 1'b1, 8'h00, 8'h0F, 8'hE0, 1'b0, -1);

        for (int i = 0; i < 20 && st_q.size() > 0; i++) step();
        check("scoreboard_drained", st_q.size(), 0);

        // One-cell chain: capture+update, then update only.
        start1 = 1'b1; capture_en1 = 1'b1; update_en1 = 1'b1;
        chip_data_out1 = 1'b0; scan_in1 = 1'b1;
        s1 = cyc + 1;
        step();
        start1 = 1'b0; capture_en1 = 1'b0; update_en1 = 1'b0;
        step();
        check("w1_scan_out", scan_out1, 0);
        check("w1_busy", busy1, 1);
        k = 0;
        while (!done1 && k < 10) begin
            step();
            k++;
        end
        check("w1_done_seen", done1, 1);
        check("w1_latency", cyc - s1 + 1, 4 + PAR);
        check("w1_chip", chip_data_in1, 1);

        start1 = 1'b1; capture_en1 = 1'b0; update_en1 = 1'b1; scan_in1 = 1'b0;
        s1 = cyc + 1;
        step();
        start1 = 1'b0; update_en1 = 1'b0;
        k = 0;
        while (!done1 && k < 10) begin
            step();
            k++;
        end
        check("w1_done_seen_2", done1, 1);
        check("w1_latency_2", cyc - s1 + 1, 3 + PAR);
        check("w1_chip_2", chip_data_in1, 0);

        step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
